// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous-read memory port between the CPU and debug requesters.
// Optional statistics outputs (conflict_cnt, dbg_starved) are built when MEM_ARB_STATS_EN is defined.
module mem_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wen,
`ifdef MEM_ARB_STATS_EN
    output logic [15:0]       conflict_cnt,
    output logic [0:0]        dbg_starved,
`endif
    input  logic [DATA_W-1:0] mem_q
);

    logic              prio_dbg_reg;
    logic              any_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_data_reg;
    logic              mem_wen_reg;
    logic [RD_LAT:0]   tag_v_reg;
    logic [RD_LAT:0]   tag_dbg_reg;
    logic [DATA_W-1:0] cpu_rdata_reg;
    logic [DATA_W-1:0] dbg_rdata_reg;

    // Grants are masked while reset is asserted so every output reads 0 during reset.
    assign cpu_gnt = rst & cpu_req & (~dbg_req | ~prio_dbg_reg);
    assign dbg_gnt = rst & dbg_req & (~cpu_req | prio_dbg_reg);
    assign any_gnt = cpu_gnt | dbg_gnt;

    always_comb begin
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        if (dbg_gnt) begin
            sel_we    = dbg_we;
            sel_addr  = dbg_addr;
            sel_wdata = dbg_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_dbg_reg <= 1'b0;
        end else if (cpu_gnt) begin
            prio_dbg_reg <= 1'b1;
        end else if (dbg_gnt) begin
            prio_dbg_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr_reg <= '0;
            mem_data_reg <= '0;
            mem_wen_reg  <= 1'b0;
        end else begin
            if (any_gnt) begin
                mem_addr_reg <= sel_addr;
            end
            mem_data_reg <= any_gnt ? sel_wdata : '0;
            mem_wen_reg  <= any_gnt & sel_we;
        end
    end

    assign mem_addr = mem_addr_reg;
    assign mem_data = mem_data_reg;
    assign mem_wen  = mem_wen_reg;

    // Owner tags travel alongside each read; stage k is valid in cycle G+1+k.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_v_reg   <= '0;
            tag_dbg_reg <= '0;
        end else begin
            tag_v_reg   <= {tag_v_reg[RD_LAT-1:0], any_gnt & ~sel_we};
            tag_dbg_reg <= {tag_dbg_reg[RD_LAT-1:0], dbg_gnt};
        end
    end

    assign cpu_rvalid = tag_v_reg[RD_LAT] & ~tag_dbg_reg[RD_LAT];
    assign dbg_rvalid = tag_v_reg[RD_LAT] & tag_dbg_reg[RD_LAT];

    // Read data is forwarded from mem_q on the rvalid cycle and held in a register afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rdata_reg <= '0;
            dbg_rdata_reg <= '0;
        end else begin
            if (cpu_rvalid) begin
                cpu_rdata_reg <= mem_q;
            end
            if (dbg_rvalid) begin
                dbg_rdata_reg <= mem_q;
            end
        end
    end

    assign cpu_rdata = cpu_rvalid ? mem_q : cpu_rdata_reg;
    assign dbg_rdata = dbg_rvalid ? mem_q : dbg_rdata_reg;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] conflict_cnt_reg;
    logic [1:0]  dbg_wait_reg;
    logic        dbg_starved_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_cnt_reg <= '0;
        end else if (cpu_req && dbg_req && conflict_cnt_reg != 16'hFFFF) begin
            conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
        end
    end

    // dbg_wait_reg counts ungranted request cycles; the fourth in a row raises dbg_starved.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbg_wait_reg    <= '0;
            dbg_starved_reg <= 1'b0;
        end else if (dbg_gnt) begin
            dbg_wait_reg    <= '0;
            dbg_starved_reg <= 1'b0;
        end else if (dbg_req) begin
            if (dbg_wait_reg == 2'd3) begin
                dbg_starved_reg <= 1'b1;
            end else begin
                dbg_wait_reg <= dbg_wait_reg + 2'd1;
            end
        end else begin
            dbg_wait_reg <= '0;
        end
    end

    assign conflict_cnt   = conflict_cnt_reg;
    assign dbg_starved[0] = dbg_starved_reg;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port main_memory (8-bit word address, 32-bit data, synchronous read) between two requesters.
  - CPU load/store path.
  - Debug/display port, used by the switch-input and 7-seg memory viewer.
- Sits between both requesters and the main_memory instance.
- Registers all memory-side signals, arbitrates round-robin, and routes returned read data to the owning requester with a fixed latency.

Parameters:
- ADDR_W, 8, memory word-address width.
- DATA_W, 32, data width.
- RD_LAT, 1, memory read latency in cycles from address registered at the memory to valid mem_q; legal values 1..3.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- cpu_req  input  1  CPU request; held until cpu_gnt.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  ADDR_W  word address.
- cpu_wdata  input  DATA_W  write data.
- cpu_gnt  output  1  one-cycle pulse; request accepted this cycle.
- cpu_rvalid  output  1  one-cycle pulse; cpu_rdata valid.
- cpu_rdata  output  DATA_W  read data.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same as the cpu_* ports, for the debug port.
- mem_addr  output  ADDR_W  to main_memory address.
- mem_data  output  DATA_W  to main_memory data.
- mem_wen  output  1  to main_memory write enable.
- mem_q  input  DATA_W  from main_memory q.

Behaviour:
- Reset (rst low, async): all outputs 0, mem_addr 0, rr pointer = CPU, read-tracking pipeline cleared.
  - No rvalid may fire for any read granted before reset.
- Arbitration, evaluated each cycle:
  - Only one requester active: grant it.
  - Both active: grant the one not granted last (rr pointer); pointer updates on every grant.
  - After reset, CPU wins the first tie.
- Maximum one grant per cycle. A requester waits at most one grant behind the other.
- gnt is combinational from req and the pointer, asserted in the accept cycle G. The requester drops or changes req after seeing gnt.
- Cycle G+1: mem_addr/mem_data/mem_wen hold the accepted request (registered at end of G).
  - mem_wen = 1 for exactly one cycle per accepted write.
  - mem_addr holds its last value when idle; mem_data = 0 and mem_wen = 0 when idle.
- Read return:
  - rvalid for the owner pulses at cycle G+1+RD_LAT.
  - rdata is registered from mem_q and holds until the next rvalid for that owner.
  - Writes produce no rvalid.
- Back-to-back: a new grant is allowed every cycle. Reads are pipelined, with an owner-tag shift register of depth RD_LAT+1. Returns arrive in grant order.
- Write then read, same address, consecutive grants: the read returns the newly written data.
- A request whose req drops before gnt is discarded, with no side effects.
- Reset mid-read: the pipeline is flushed, mem_wen is forced 0, and an in-flight write is not guaranteed to complete.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined:
  - Adds output port conflict_cnt [15:0]: increments on each cycle both req are high, saturates at 16'hFFFF, cleared by reset.
  - Adds output port dbg_starved [0:0]: set when dbg_req has been held 4 consecutive cycles without grant; cleared on dbg_gnt or reset.
- Undefined: neither port exists; arbitration behaviour is identical.

Test Plan:
- After reset, cpu write 0xDEADBEEF to addr 0x10 (single request) -> cpu_gnt in cycle 0; mem_wen=1, mem_addr=0x10 in cycle 1; no cpu_rvalid.
- cpu read 0x10 granted at cycle G, RD_LAT=1 -> cpu_rvalid at G+2 with cpu_rdata=0xDEADBEEF; dbg_rvalid stays 0.
- cpu and dbg both request reads continuously for 4 cycles -> grants alternate CPU,DBG,CPU,DBG; rvalid pulses alternate in the same order; with MEM_ARB_STATS_EN, conflict_cnt=4.
- dbg write 0x00000005 to addr 0x20 then cpu read 0x20 in the next cycle -> cpu_rdata=0x00000005.
- cpu read granted, rst pulsed low at G+1 -> all outputs 0 immediately; no cpu_rvalid after reset release; first tie after release goes to CPU.
- RD_LAT=3, three consecutive cpu reads of 0x01,0x02,0x03 preloaded 0xA,0xB,0xC -> cpu_rvalid on G+4, G+5, G+6 with 0xA, 0xB, 0xC.
